// File: rtl/lz77_dec.sv
// LZ77 token decoder: expands literal/match tokens into a byte stream through a sliding window.
// Optional illegal-token checking is compiled in with `define LZ77_DEC_CHK_EN.
module lz77_dec #(
    parameter int unsigned DATA_CHN_WD = 8,
    parameter int unsigned SIZE_LEN_WD = 9,
    parameter int unsigned SIZE_DST_WD = 15,
    parameter int unsigned WIN_WD      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   done_o,
    output logic                   err_o,
    input  logic                   val_i,
    output logic                   rdy_o,
    input  logic                   flg_lit_i,
    input  logic [DATA_CHN_WD-1:0] dat_lit_i,
    input  logic [SIZE_LEN_WD-1:0] dat_len_i,
    input  logic [SIZE_DST_WD-1:0] dat_dst_i,
    input  logic                   flg_lst_i,
    output logic                   val_o,
    output logic [DATA_CHN_WD-1:0] dat_o,
    output logic                   lst_o,
    input  logic                   rdy_i
);

    localparam int unsigned Depth = 1 << WIN_WD;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StCopy  = 2'd2,
        StFlush = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [DATA_CHN_WD-1:0] mem_q [Depth];
    logic [WIN_WD-1:0]      wptr_q, wptr_d;
    logic [WIN_WD:0]        fil_q, fil_d;
    logic [WIN_WD-1:0]      dst_q, dst_d;
    logic [SIZE_LEN_WD-1:0] rem_q, rem_d;
    logic                   lst_pend_q, lst_pend_d;
    logic                   val_q, val_d;
    logic [DATA_CHN_WD-1:0] dat_q, dat_d;
    logic                   lst_q, lst_d;
    logic                   done_q, done_d;

    logic                   adv;
    logic                   tok_acc;
    logic                   tok_bad;
    logic                   wr_en;
    logic [WIN_WD-1:0]      rd_addr_tok, rd_addr_cpy;
    logic [DATA_CHN_WD-1:0] rd_tok, rd_cpy;

    assign adv     = !val_q || rdy_i;
    assign tok_acc = val_i && rdy_o;

    // Only the low WIN_WD bits of the distance matter: the window address wraps.
    assign rd_addr_tok = wptr_q - WIN_WD'(dat_dst_i);
    assign rd_addr_cpy = wptr_q - dst_q;
    assign rd_tok      = mem_q[rd_addr_tok];
    assign rd_cpy      = mem_q[rd_addr_cpy];

`ifdef LZ77_DEC_CHK_EN
    logic        err_q, err_d;
    logic [31:0] dst_ext, fil_ext, len_ext;

    assign dst_ext = 32'(dat_dst_i);
    assign fil_ext = 32'(fil_q);
    assign len_ext = 32'(dat_len_i);
    assign tok_bad = !flg_lit_i &&
                     ((dst_ext == 32'd0) || (dst_ext > fil_ext) || (dst_ext > Depth) ||
                      (len_ext < 32'd3));

    always_comb begin
        err_d = err_q;
        if (state_q == StIdle && start_i) begin
            err_d = 1'b0;
        end else if (tok_acc && tok_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_dst;

    assign unused_dst = ^dat_dst_i;
    assign tok_bad    = 1'b0;
    assign err_o      = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            fil_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            lst_pend_q <= 1'b0;
            val_q      <= 1'b0;
            dat_q      <= '0;
            lst_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            fil_q      <= fil_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            lst_pend_q <= lst_pend_d;
            val_q      <= val_d;
            dat_q      <= dat_d;
            lst_q      <= lst_d;
            done_q     <= done_d;
        end
    end

    // History window: every emitted byte is stored as it loads the output register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= dat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        dat_d      = dat_q;
        lst_d      = lst_q;
        done_d     = 1'b0;
        rem_d      = rem_q;
        dst_d      = dst_q;
        lst_pend_d = lst_pend_q;
        wr_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (adv) begin
                    val_d = 1'b0;
                    lst_d = 1'b0;
                end
                if (tok_acc) begin
                    if (tok_bad) begin
                        if (flg_lst_i) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else if (flg_lit_i) begin
                        val_d = 1'b1;
                        dat_d = dat_lit_i;
                        lst_d = flg_lst_i;
                        wr_en = 1'b1;
                        if (flg_lst_i) begin
                            state_d = StFlush;
                        end
                    end else begin
                        val_d      = 1'b1;
                        dat_d      = rd_tok;
                        wr_en      = 1'b1;
                        dst_d      = WIN_WD'(dat_dst_i);
                        rem_d      = dat_len_i - SIZE_LEN_WD'(1);
                        lst_pend_d = flg_lst_i;
                        // A degenerate length (unchecked build) emits a single byte.
                        if (dat_len_i > SIZE_LEN_WD'(1)) begin
                            state_d = StCopy;
                        end else begin
                            lst_d = flg_lst_i;
                            if (flg_lst_i) begin
                                state_d = StFlush;
                            end
                        end
                    end
                end
            end
            StCopy: begin
                if (adv) begin
                    val_d = 1'b1;
                    dat_d = rd_cpy;
                    wr_en = 1'b1;
                    rem_d = rem_q - SIZE_LEN_WD'(1);
                    if (rem_q == SIZE_LEN_WD'(1)) begin
                        lst_d   = lst_pend_q;
                        state_d = lst_pend_q ? StFlush : StRun;
                    end
                end
            end
            StFlush: begin
                if (val_q && rdy_i) begin
                    val_d   = 1'b0;
                    lst_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        wptr_d = wptr_q;
        fil_d  = fil_q;
        if (wr_en) begin
            wptr_d = wptr_q + WIN_WD'(1);
            if (fil_q != (WIN_WD + 1)'(Depth)) begin
                fil_d = fil_q + (WIN_WD + 1)'(1);
            end
        end
    end

    // Outputs.
    always_comb begin
        rdy_o = 1'b0;
        if (state_q == StRun) begin
            rdy_o = adv;
        end
    end

    assign val_o  = val_q;
    assign dat_o  = dat_q;
    assign lst_o  = lst_q;
    assign done_o = done_q;

endmodule
